// File: rtl/tank_plant_model_if.sv
// Command/sensor bundle between the pump controller (master) and the
// two-tank plant model (slave).
interface tank_plant_model_if #(
  parameter int LW = 8
);
  logic          B1;
  logic          B2;
  logic          Consume;
  logic          ClearFlags;
  logic          S1;
  logic          S2;
  logic          S3;
  logic          S4;
  logic [LW-1:0] Level1;
  logic [LW-1:0] Level2;
  logic          Overflow1;
  logic          Overflow2;
  logic          DryRun;

  modport master (
    output B1, B2, Consume, ClearFlags,
    input  S1, S2, S3, S4, Level1, Level2, Overflow1, Overflow2, DryRun
  );

  modport slave (
    input  B1, B2, Consume, ClearFlags,
    output S1, S2, S3, S4, Level1, Level2, Overflow1, Overflow2, DryRun
  );
endinterface

// File: rtl/tank_plant_model.sv
// Behavioural plant model of a cistern (tank 1) feeding an elevated tank
// (tank 2). Levels are saturating counters advanced once per prescaled tick;
// level sensors and sticky fault flags are all registered outputs.
module tank_plant_model #(
  parameter int LW       = 8,
  parameter int CAP1     = 200,
  parameter int CAP2     = 200,
  parameter int LOW1     = 40,
  parameter int HIGH1    = 160,
  parameter int LOW2     = 40,
  parameter int HIGH2    = 160,
  parameter int INFLOW   = 4,
  parameter int XFER     = 3,
  parameter int DRAIN    = 2,
  parameter int TICK_DIV = 4,
  parameter int INIT1    = 0,
  parameter int INIT2    = 0
) (
  input logic               Clock,
  input logic               Reset,
  tank_plant_model_if.slave bus
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  // Wide (LW+1) constants so intermediate sums cannot wrap.
  localparam logic [LW:0]   CAP1_W   = (LW+1)'(CAP1);
  localparam logic [LW:0]   CAP2_W   = (LW+1)'(CAP2);
  localparam logic [LW:0]   INFLOW_W = (LW+1)'(INFLOW);
  localparam logic [LW:0]   XFER_W   = (LW+1)'(XFER);
  localparam logic [LW:0]   DRAIN_W  = (LW+1)'(DRAIN);
  localparam logic [LW-1:0] CAP1_L   = LW'(CAP1);
  localparam logic [LW-1:0] CAP2_L   = LW'(CAP2);
  localparam logic [LW-1:0] LOW1_L   = LW'(LOW1);
  localparam logic [LW-1:0] HIGH1_L  = LW'(HIGH1);
  localparam logic [LW-1:0] LOW2_L   = LW'(LOW2);
  localparam logic [LW-1:0] HIGH2_L  = LW'(HIGH2);
  localparam logic [LW-1:0] INIT1_L  = LW'(INIT1);
  localparam logic [LW-1:0] INIT2_L  = LW'(INIT2);
  localparam logic [TW-1:0] TICK_END = TW'(TICK_DIV - 1);

  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [LW-1:0] level1;
  logic [LW-1:0] level2;
  logic          s1, s2, s3, s4;
  logic          overflow1, overflow2, dry_run;

  logic [LW:0]   l1_w, l2_w, room2, xfer, inflow, sum1, drain, sum2;
  logic          set_of1, set_of2, set_dry;
  logic [LW-1:0] next_l1, next_l2;
  logic          next_of1, next_of2, next_dry;

  function automatic logic [LW:0] min2(input logic [LW:0] a, input logic [LW:0] b);
    if (a < b) begin
      min2 = a;
    end else begin
      min2 = b;
    end
  endfunction

  // Tick strobe: last count of the prescaler.
  always_comb begin
    tick = (tick_cnt == TICK_END);
  end

  // Per-tick water balance; transfer uses only water already in tank 1.
  always_comb begin
    l1_w  = {1'b0, level1};
    l2_w  = {1'b0, level2};
    room2 = CAP2_W - l2_w;
    if (bus.B2) begin
      xfer = min2(min2(XFER_W, l1_w), room2);
    end else begin
      xfer = '0;
    end
    if (bus.B1) begin
      inflow = INFLOW_W;
    end else begin
      inflow = '0;
    end
    sum1 = l1_w - xfer + inflow;
    if (bus.Consume) begin
      drain = min2(DRAIN_W, l2_w + xfer);
    end else begin
      drain = '0;
    end
    sum2    = l2_w + xfer - drain;
    set_of1 = (sum1 > CAP1_W);
    set_of2 = bus.B2 && ((l2_w + XFER_W) > CAP2_W);
    set_dry = bus.B2 && (l1_w < XFER_W);
  end

  // Next state: levels move only on ticks; clear first, then tick sets win.
  always_comb begin
    next_l1  = level1;
    next_l2  = level2;
    next_of1 = overflow1 && !bus.ClearFlags;
    next_of2 = overflow2 && !bus.ClearFlags;
    next_dry = dry_run && !bus.ClearFlags;
    if (tick) begin
      if (sum1 > CAP1_W) begin
        next_l1 = CAP1_L;
      end else begin
        next_l1 = sum1[LW-1:0];
      end
      if (sum2 > CAP2_W) begin
        next_l2 = CAP2_L;
      end else begin
        next_l2 = sum2[LW-1:0];
      end
      next_of1 = next_of1 || set_of1;
      next_of2 = next_of2 || set_of2;
      next_dry = next_dry || set_dry;
    end else begin
      next_l1 = level1;
      next_l2 = level2;
    end
  end

  // State registers; sensors are registered from the next levels so they
  // change on the same edge as the level they describe.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      tick_cnt  <= '0;
      level1    <= INIT1_L;
      level2    <= INIT2_L;
      s1        <= (INIT1_L >= LOW1_L);
      s2        <= (INIT1_L >= HIGH1_L);
      s3        <= (INIT2_L >= LOW2_L);
      s4        <= (INIT2_L >= HIGH2_L);
      overflow1 <= 1'b0;
      overflow2 <= 1'b0;
      dry_run   <= 1'b0;
    end else begin
      if (tick) begin
        tick_cnt <= '0;
      end else begin
        tick_cnt <= tick_cnt + TW'(1);
      end
      level1    <= next_l1;
      level2    <= next_l2;
      s1        <= (next_l1 >= LOW1_L);
      s2        <= (next_l1 >= HIGH1_L);
      s3        <= (next_l2 >= LOW2_L);
      s4        <= (next_l2 >= HIGH2_L);
      overflow1 <= next_of1;
      overflow2 <= next_of2;
      dry_run   <= next_dry;
    end
  end

  assign bus.Level1    = level1;
  assign bus.Level2    = level2;
  assign bus.S1        = s1;
  assign bus.S2        = s2;
  assign bus.S3        = s3;
  assign bus.S4        = s4;
  assign bus.Overflow1 = overflow1;
  assign bus.Overflow2 = overflow2;
  assign bus.DryRun    = dry_run;

endmodule

// File: tb/tb_tank_plant_model.sv
// Bench for tank_plant_model: three instances with different prescaler and
// initial levels share one stimulus stream. A water-balance model predicts
// each instance's state after every clock; a monitor compares.
module tb_tank_plant_model;

  localparam int CAP1 = 200, CAP2 = 200, LOW1 = 40, HIGH1 = 160, LOW2 = 40, HIGH2 = 160;
  localparam int INFLOW = 4, XFER = 3, DRAIN = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic b1 = 1'b0, b2 = 1'b0, con = 1'b0, clr = 1'b0;

  always #5 clk = ~clk;

  tank_plant_model_if #(.LW(8)) if0 ();
  tank_plant_model_if #(.LW(8)) if1 ();
  tank_plant_model_if #(.LW(8)) if2 ();

  assign if0.B1 = b1; assign if0.B2 = b2; assign if0.Consume = con; assign if0.ClearFlags = clr;
  assign if1.B1 = b1; assign if1.B2 = b2; assign if1.Consume = con; assign if1.ClearFlags = clr;
  assign if2.B1 = b1; assign if2.B2 = b2; assign if2.Consume = con; assign if2.ClearFlags = clr;

  tank_plant_model dut0 (.Clock(clk), .Reset(rst), .bus(if0.slave));
  tank_plant_model #(.TICK_DIV(1), .INIT1(100), .INIT2(100)) dut1 (.Clock(clk), .Reset(rst), .bus(if1.slave));
  tank_plant_model #(.TICK_DIV(1), .INIT1(50), .INIT2(199)) dut2 (.Clock(clk), .Reset(rst), .bus(if2.slave));

  // Model parameters per instance.
  int tdiv [3] = '{4, 1, 1};
  int init1[3] = '{0, 100, 50};
  int init2[3] = '{0, 100, 199};

  // Model state per instance.
  int ml1[3], ml2[3], mph[3];
  bit mo1[3], mo2[3], mdr[3];

  typedef struct packed {
    logic [1:0]  idx;
    logic [22:0] v;   // {Level1, Level2, S1..S4, Overflow1, Overflow2, DryRun}
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int passes = 0;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Advance the model of instance d across one clock edge with current inputs.
  task automatic model_step(input int d);
    int   xf, inn, raw, dr;
    bit   tk;
    exp_t e;
    if (rst) begin
      ml1[d] = init1[d]; ml2[d] = init2[d]; mph[d] = 0;
      mo1[d] = 0; mo2[d] = 0; mdr[d] = 0;
    end else begin
      tk = (mph[d] == tdiv[d] - 1);
      mph[d] = tk ? 0 : mph[d] + 1;
      if (clr) begin
        mo1[d] = 0; mo2[d] = 0; mdr[d] = 0;
      end
      if (tk) begin
        xf  = b2 ? imin(imin(XFER, ml1[d]), CAP2 - ml2[d]) : 0;
        inn = b1 ? INFLOW : 0;
        raw = ml1[d] - xf + inn;
        if (raw > CAP1) mo1[d] = 1;
        if (b2 && (ml2[d] + XFER > CAP2)) mo2[d] = 1;
        if (b2 && (ml1[d] < XFER)) mdr[d] = 1;
        dr = con ? imin(DRAIN, ml2[d] + xf) : 0;
        ml2[d] = ml2[d] + xf - dr;
        ml1[d] = (raw > CAP1) ? CAP1 : raw;
      end
    end
    e.idx = 2'(d);
    e.v = {8'(ml1[d]), 8'(ml2[d]),
           ml1[d] >= LOW1, ml1[d] >= HIGH1, ml2[d] >= LOW2, ml2[d] >= HIGH2,
           mo1[d], mo2[d], mdr[d]};
    exp_q.push_back(e);
  endtask

  // Drive one clock's worth of inputs and record expected results.
  task automatic cycle(input logic r, input logic p1, input logic p2, input logic c, input logic cl);
    @(negedge clk);
    rst = r; b1 = p1; b2 = p2; con = c; clr = cl;
    for (int d = 0; d < 3; d++) model_step(d);
  endtask

  // Monitor: after each active edge, compare every pending expectation.
  initial begin
    exp_t        e;
    logic [22:0] act;
    forever begin
      @(posedge clk);
      #1;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        case (e.idx)
          2'd0:    act = {if0.Level1, if0.Level2, if0.S1, if0.S2, if0.S3, if0.S4, if0.Overflow1, if0.Overflow2, if0.DryRun};
          2'd1:    act = {if1.Level1, if1.Level2, if1.S1, if1.S2, if1.S3, if1.S4, if1.Overflow1, if1.Overflow2, if1.DryRun};
          default: act = {if2.Level1, if2.Level2, if2.S1, if2.S2, if2.S3, if2.S4, if2.Overflow1, if2.Overflow2, if2.DryRun};
        endcase
        checks++;
        if (act === e.v) begin
          passes++;
        end else begin
          $display("FAIL dut%0d_state at %0t: got L1=%0d L2=%0d S=%b flags=%b, expected L1=%0d L2=%0d S=%b flags=%b",
                   e.idx, $time, act[22:15], act[14:7], act[6:3], act[2:0],
                   e.v[22:15], e.v[14:7], e.v[6:3], e.v[2:0]);
        end
      end
    end
  end

  // Stimulus: directed scenarios followed by randomized traffic.
  initial begin
    // Fill tank 1 to the brim and beyond, then clear the spill flag.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (210) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (8) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Small fill then transfer until tank 1 runs dry.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (12) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (30) cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // All three flows at once.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (20) cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);

    // Transfer into a nearly full tank 2.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (10) cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Randomized traffic with occasional reset and flag clears.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2000; i++) begin
      cycle(($urandom_range(0, 149) == 0),
            ($urandom_range(0, 9) < 6),
            ($urandom_range(0, 9) < 5),
            ($urandom_range(0, 9) < 4),
            ($urandom_range(0, 11) == 0));
    end

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() == 0) begin
      passes++;
    end else begin
      $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
